operand_sequencer: RTL

OPERAND_SEQUENCER -- requirements
Module: operand_sequencer

---
 rtl/operand_sequencer.sv | 77 +++++++
 1 files changed

// File: rtl/operand_sequencer.sv
// Operand sequencer: collects two operands from a valid/ready source, presents them
// to an external adder, registers the WIDTH+1 sum and offers it on a valid/ready sink.
module operand_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  input  logic [WIDTH:0]   sum_in,
  output logic [WIDTH:0]   out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    EXEC   = 2'd2,
    OUT    = 2'd3
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] op_a_reg;
  logic [WIDTH-1:0] op_b_reg;
  logic [WIDTH:0]   out_data_reg;
  logic             in_fire;
  logic             out_fire;

  // Handshake outputs depend only on the state register and reset, never on
  // in_valid/out_ready, so no combinational loop can form through the neighbours.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    if (!rst) begin
      in_ready  = (state_reg == LOAD_A) || (state_reg == LOAD_B);
      out_valid = (state_reg == OUT);
      busy      = (state_reg != LOAD_A);
    end
    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    case (state_reg)
      LOAD_A:  if (in_fire) state_next = LOAD_B;
      LOAD_B:  if (in_fire) state_next = EXEC;
      EXEC:    state_next = OUT;
      OUT:     if (out_fire) state_next = LOAD_A;
      default: state_next = LOAD_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= LOAD_A;
      op_a_reg     <= '0;
      op_b_reg     <= '0;
      out_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (in_fire && state_reg == LOAD_A) op_a_reg <= in_data;
      if (in_fire && state_reg == LOAD_B) op_b_reg <= in_data;
      // The adder has had the whole EXEC cycle to settle on the held operands.
      if (state_reg == EXEC) out_data_reg <= sum_in;
    end
  end

  assign op_a     = op_a_reg;
  assign op_b     = op_b_reg;
  assign out_data = out_data_reg;

endmodule
